// File: rtl/vec_reg_stream_out_if.sv
// Valid/ready stream toward the host link: one BITS-wide word per beat,
// with a last marker qualified by valid.
interface vec_reg_stream_out_if #(
  parameter int unsigned BITS = 8
) ();
  logic [BITS-1:0] data;
  logic            valid;
  logic            ready;
  logic            last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/vec_reg_stream_out.sv
// Vector store unit: reads one register from a vec_reg_bank read port,
// snapshots it, and streams its elements out one per beat.
// Optional feature macro: VEC_STREAM_HDR_EN -- when defined, every transfer
// starts with one length word (a zero-length vector emits just that word).
module vec_reg_stream_out #(
  parameter int unsigned BITS = 8,
  parameter int unsigned N    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [3:0]              sel,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              bank_sel,
  output logic                    bank_en,
  input  logic [BITS-1:0]         bank_data [N-1:0],
  input  logic [7:0]              bank_len,
  vec_reg_stream_out_if.master    tx
);

  localparam int unsigned IW = $clog2(N) + 1;
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LW = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
`ifdef VEC_STREAM_HDR_EN
    HDR,
`endif
    SEND,
    DONE
  } state_t;

  state_t          state;
  logic [BITS-1:0] snap [N-1:0];
  logic [LW-1:0]   len;
  logic [IW-1:0]   idx;

  logic [LW-1:0]   len_clamp_c;
  logic [IW-1:0]   idx_nxt_c;
  logic            last_nxt_c;

  // Length clamp on the bank's reported length and next-word bookkeeping.
  always_comb begin
    len_clamp_c = (bank_len > LW'(N)) ? LW'(N) : bank_len;
    idx_nxt_c   = idx + IW'(1);
    last_nxt_c  = (LW'(idx_nxt_c) == (len - LW'(1)));
  end

  // Transfer sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bank_sel <= 4'd0;
      bank_en  <= 1'b0;
      tx.data  <= '0;
      tx.valid <= 1'b0;
      tx.last  <= 1'b0;
      len      <= '0;
      idx      <= '0;
      for (int i = 0; i < int'(N); i++) snap[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bank_sel <= sel;
            bank_en  <= 1'b1;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          bank_en <= 1'b0;
          for (int i = 0; i < int'(N); i++) snap[i] <= bank_data[i];
          len     <= len_clamp_c;
          idx     <= '0;
`ifdef VEC_STREAM_HDR_EN
          tx.data  <= BITS'(len_clamp_c);
          tx.valid <= 1'b1;
          tx.last  <= (len_clamp_c == '0);
          state    <= HDR;
`else
          if (len_clamp_c != '0) begin
            tx.data  <= bank_data[0];
            tx.valid <= 1'b1;
            tx.last  <= (len_clamp_c == LW'(1));
            state    <= SEND;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
`endif
        end
`ifdef VEC_STREAM_HDR_EN
        HDR: begin
          if (tx.ready) begin
            if (len != '0) begin
              tx.data <= snap[0];
              tx.last <= (len == LW'(1));
              state   <= SEND;
            end else begin
              tx.valid <= 1'b0;
              tx.last  <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
`endif
        SEND: begin
          if (tx.ready) begin
            if (tx.last) begin
              tx.valid <= 1'b0;
              tx.last  <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              idx     <= idx_nxt_c;
              tx.data <= snap[SW'(idx_nxt_c)];
              tx.last <= last_nxt_c;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy     <= 1'b0;
          bank_en  <= 1'b0;
          tx.valid <= 1'b0;
          tx.last  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
